// File: rtl/scan_frame_packer_pkg.sv
// Shared definitions for the scan frame packer: FSM state encodings and sync byte defaults.
// The CSUM/END states exist only in the build that matches the CHECKSUM_EN macro.
package scan_frame_packer_pkg;

    localparam logic [3:0] ST_IDLE  = 4'd0;
    localparam logic [3:0] ST_SYNC0 = 4'd1;
    localparam logic [3:0] ST_SYNC1 = 4'd2;
    localparam logic [3:0] ST_FCNT  = 4'd3;
    localparam logic [3:0] ST_S_HI  = 4'd4;
    localparam logic [3:0] ST_S_LO  = 4'd5;
    localparam logic [3:0] ST_WAIT  = 4'd6;
`ifdef CHECKSUM_EN
    localparam logic [3:0] ST_CSUM  = 4'd8;
`else
    localparam logic [3:0] ST_END   = 4'd7;
`endif

    localparam logic [7:0] SYNC0_DEFAULT = 8'hFF;
    localparam logic [7:0] SYNC1_DEFAULT = 8'hA5;

endpackage

// File: rtl/scan_byte_fifo.sv
// First-word fall-through byte FIFO; dout reads zero while empty.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module scan_byte_fifo #(
    parameter int DEPTH = 64
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] din,
    output logic       full,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    // The extra pointer bit distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/scan_frame_packer.sv
// Frames scan samples into sync/count/sample bytes and queues them for the UART.
// Define CHECKSUM_EN to append an XOR checksum byte (over count and sample bytes) to every frame.
module scan_frame_packer
    import scan_frame_packer_pkg::*;
#(
    parameter int          SAMPLE_W   = 12,
    parameter int          FIFO_DEPTH = 64,
    parameter logic [7:0]  SYNC0      = SYNC0_DEFAULT,
    parameter logic [7:0]  SYNC1      = SYNC1_DEFAULT
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample_data,
    input  logic                head,
    input  logic                tail,
    output logic                sample_ready,
    output logic                tx_valid,
    output logic [7:0]          tx_data,
    input  logic                tx_ready,
    output logic                frame_err,
    output logic                busy
);

    logic [3:0]          state;
    logic [SAMPLE_W-1:0] sample_reg;
    logic                sample_tail;
    logic [15:0]         sample_ext;
    logic [7:0]          frame_cnt;
    logic                sample_accept;
    logic                fifo_push;
    logic [7:0]          fifo_din;
    logic                fifo_full;
    logic                fifo_empty;
`ifdef CHECKSUM_EN
    logic [7:0]          csum;
`endif

    assign sample_ready  = (state == ST_IDLE) || (state == ST_WAIT);
    assign sample_accept = sample_valid && sample_ready;
    assign sample_ext    = 16'(sample_reg);
    assign tx_valid      = !fifo_empty;
    assign busy          = (state != ST_IDLE) || !fifo_empty;

    always_comb begin
        fifo_push = 1'b0;
        fifo_din  = 8'h00;
        if (!fifo_full) begin
            case (state)
                ST_SYNC0: begin fifo_push = 1'b1; fifo_din = SYNC0;            end
                ST_SYNC1: begin fifo_push = 1'b1; fifo_din = SYNC1;            end
                ST_FCNT:  begin fifo_push = 1'b1; fifo_din = frame_cnt;        end
                ST_S_HI:  begin fifo_push = 1'b1; fifo_din = sample_ext[15:8]; end
                ST_S_LO:  begin fifo_push = 1'b1; fifo_din = sample_ext[7:0];  end
`ifdef CHECKSUM_EN
                ST_CSUM:  begin fifo_push = 1'b1; fifo_din = csum;             end
`endif
                default: ;
            endcase
        end
    end

    // Byte-emitting states advance only on a cycle in which their byte was pushed.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            sample_reg  <= '0;
            sample_tail <= 1'b0;
            frame_cnt   <= 8'h00;
            frame_err   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (sample_accept) begin
                sample_reg  <= sample_data;
                sample_tail <= tail;
            end
            case (state)
                ST_IDLE:  if (sample_accept && head) state <= ST_SYNC0;
                ST_WAIT: begin
                    if (sample_accept) begin
                        if (head) begin
                            frame_err <= 1'b1;
                            state     <= ST_SYNC0;
                        end else begin
                            state <= ST_S_HI;
                        end
                    end
                end
                ST_SYNC0: if (fifo_push) state <= ST_SYNC1;
                ST_SYNC1: if (fifo_push) state <= ST_FCNT;
                ST_FCNT:  if (fifo_push) state <= ST_S_HI;
                ST_S_HI:  if (fifo_push) state <= ST_S_LO;
                ST_S_LO: begin
                    if (fifo_push) begin
`ifdef CHECKSUM_EN
                        state <= sample_tail ? ST_CSUM : ST_WAIT;
`else
                        state <= sample_tail ? ST_END : ST_WAIT;
`endif
                    end
                end
`ifdef CHECKSUM_EN
                ST_CSUM: begin
                    if (fifo_push) begin
                        frame_cnt <= frame_cnt + 8'd1;
                        state     <= ST_IDLE;
                    end
                end
`else
                ST_END: begin
                    frame_cnt <= frame_cnt + 8'd1;
                    state     <= ST_IDLE;
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef CHECKSUM_EN
    // Sync bytes never enter the checksum; an aborted frame restarts it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            csum <= 8'h00;
        end else if ((state == ST_SYNC0) || ((state == ST_WAIT) && sample_accept && head)) begin
            csum <= 8'h00;
        end else if (fifo_push && ((state == ST_FCNT) || (state == ST_S_HI) || (state == ST_S_LO))) begin
            csum <= csum ^ fifo_din;
        end
    end
`endif

    scan_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (fifo_push),
        .din   (fifo_din),
        .full  (fifo_full),
        .pop   (tx_ready),
        .dout  (tx_data),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_scan_frame_packer.sv
// Scoreboard bench for scan_frame_packer; expected bytes are queued as samples are issued.
// Build with CHECKSUM_EN defined to expect the trailing checksum byte.
`timescale 1ns/1ps
module tb_scan_frame_packer;
    import scan_frame_packer_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        sample_valid = 1'b0;
    logic [11:0] sample_data = 12'h000;
    logic        head = 1'b0;
    logic        tail = 1'b0;
    logic        tx_ready = 1'b1;
    logic        sample_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        frame_err;
    logic        busy;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_q [$];
    int          err_pulses = 0;
    int          exp_err = 0;
    logic [7:0]  m_fcnt = 8'h00;
    logic [7:0]  m_csum = 8'h00;
    bit          m_in_frame = 1'b0;
    bit          held_v = 1'b0;
    logic [7:0]  held_d = 8'h00;

    scan_frame_packer #(
        .SAMPLE_W   (12),
        .FIFO_DEPTH (16),
        .SYNC0      (8'hFF),
        .SYNC1      (8'hA5)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .head         (head),
        .tail         (tail),
        .sample_ready (sample_ready),
        .tx_valid     (tx_valid),
        .tx_data      (tx_data),
        .tx_ready     (tx_ready),
        .frame_err    (frame_err),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every byte the UART takes must match the head of the scoreboard queue.
    always @(negedge clock) begin
        if (reset) begin
            held_v <= 1'b0;
        end else begin
            if (frame_err) err_pulses++;
            if (held_v && tx_valid) check_output("tx_hold", {24'h0, tx_data}, {24'h0, held_d});
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_byte: got %02h expected none", tx_data);
                end else begin
                    check_output("tx_byte", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
                end
            end
            held_v <= tx_valid && !tx_ready;
            held_d <= tx_data;
        end
    end

    // Holds a sample until the packer accepts it; returns just after the accepting edge.
    task automatic apply_stimulus(input logic [11:0] d, input logic h, input logic t);
        int n;
        n = 0;
        sample_valid = 1'b1;
        sample_data  = d;
        head         = h;
        tail         = t;
        forever begin
            @(negedge clock);
            n++;
            if (sample_ready) begin
                @(posedge clock);
                #1;
                break;
            end
            if (n > 3000) begin
                check_output("accept_timeout", 32'd0, 32'd1);
                break;
            end
        end
        sample_valid = 1'b0;
        head         = 1'b0;
        tail         = 1'b0;
    endtask

    task automatic scan_point(input logic [11:0] d, input bit h, input bit t);
        logic [7:0] hi;
        logic [7:0] lo;
        hi = {4'h0, d[11:8]};
        lo = d[7:0];
        if (h) begin
            if (m_in_frame) exp_err++;
            exp_q.push_back(8'hFF);
            exp_q.push_back(8'hA5);
            exp_q.push_back(m_fcnt);
            m_csum     = m_fcnt;
            m_in_frame = 1'b1;
        end
        if (m_in_frame) begin
            exp_q.push_back(hi);
            exp_q.push_back(lo);
            m_csum = m_csum ^ hi ^ lo;
            if (t) begin
`ifdef CHECKSUM_EN
                exp_q.push_back(m_csum);
`endif
                m_fcnt     = m_fcnt + 8'd1;
                m_in_frame = 1'b0;
            end
        end
        apply_stimulus(d, h, t);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 5000) begin
            @(posedge clock);
            n++;
        end
        #1;
        check_output({name, "_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: got running expected finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        repeat (3) @(posedge clock);
        #1;
        check_output("rst_tx_valid", tx_valid, 0);
        check_output("rst_tx_data", {24'h0, tx_data}, 0);
        check_output("rst_frame_err", frame_err, 0);
        check_output("rst_busy", busy, 0);
        reset = 1'b0;
        @(negedge clock);
        check_output("rst_sample_ready", sample_ready, 1);
        @(posedge clock);
        #1;

        // Samples before any head are dropped.
        apply_stimulus(12'h111, 1'b0, 1'b0);
        apply_stimulus(12'h222, 1'b0, 1'b1);

        // Three-sample scan with literal expected bytes.
        exp_q.push_back(8'hFF); exp_q.push_back(8'hA5); exp_q.push_back(8'h00);
        exp_q.push_back(8'h01); exp_q.push_back(8'h23);
        exp_q.push_back(8'h04); exp_q.push_back(8'h56);
        exp_q.push_back(8'h07); exp_q.push_back(8'h89);
`ifdef CHECKSUM_EN
        exp_q.push_back(8'hFE);
`endif
        apply_stimulus(12'h123, 1'b1, 1'b0);
        apply_stimulus(12'h456, 1'b0, 1'b0);
        apply_stimulus(12'h789, 1'b0, 1'b1);
        m_fcnt = 8'h01;
        wait_drain("frame1");

        scan_point(12'hABC, 1'b1, 1'b0);
        scan_point(12'hDEF, 1'b0, 1'b1);
        wait_drain("frame2");

        // UART stalls while a long frame is produced; nothing may be dropped.
        tx_ready = 1'b0;
        fork
            begin
                scan_point(12'h100, 1'b1, 1'b0);
                for (int i = 1; i < 39; i++) scan_point(12'(i * 7), 1'b0, 1'b0);
                scan_point(12'hABC, 1'b0, 1'b1);
            end
            begin
                repeat (100) @(posedge clock);
                @(negedge clock);
                check_output("stall_sample_ready", sample_ready, 0);
                check_output("stall_tx_valid", tx_valid, 1);
                check_output("stall_busy", busy, 1);
                @(posedge clock);
                #1;
                tx_ready = 1'b1;
            end
        join
        wait_drain("stall");

        // Single-point frames until the frame counter wraps past 255.
        while (m_fcnt != 8'hFF) scan_point({4'h0, m_fcnt}, 1'b1, 1'b1);
        scan_point(12'h321, 1'b1, 1'b1);
        scan_point(12'h654, 1'b1, 1'b1);
        wait_drain("wrap");

        // Reset with five bytes still queued.
        tx_ready = 1'b0;
        scan_point(12'h5A5, 1'b1, 1'b0);
        repeat (6) @(posedge clock);
        #1;
        check_output("pre_reset_busy", busy, 1);
        reset = 1'b1;
        #1;
        check_output("reset_tx_valid", tx_valid, 0);
        exp_q.delete();
        m_fcnt     = 8'h00;
        m_csum     = 8'h00;
        m_in_frame = 1'b0;
        @(posedge clock);
        #1;
        reset    = 1'b0;
        tx_ready = 1'b1;
        @(negedge clock);
        check_output("post_reset_busy", busy, 0);
        check_output("post_reset_ready", sample_ready, 1);
        @(posedge clock);
        #1;

        // Early head aborts a frame; the restarted frame reuses count 00.
        exp_q.push_back(8'hFF); exp_q.push_back(8'hA5); exp_q.push_back(8'h00);
        exp_q.push_back(8'h00); exp_q.push_back(8'h11);
        exp_q.push_back(8'h00); exp_q.push_back(8'h22);
        exp_q.push_back(8'hFF); exp_q.push_back(8'hA5); exp_q.push_back(8'h00);
        exp_q.push_back(8'h00); exp_q.push_back(8'h33);
        exp_q.push_back(8'h00); exp_q.push_back(8'h44);
`ifdef CHECKSUM_EN
        exp_q.push_back(8'h77);
`endif
        apply_stimulus(12'h011, 1'b1, 1'b0);
        apply_stimulus(12'h022, 1'b0, 1'b0);
        apply_stimulus(12'h033, 1'b1, 1'b0);
        apply_stimulus(12'h044, 1'b0, 1'b1);
        exp_err++;
        m_fcnt = 8'h01;
        wait_drain("abort");
        check_output("frame_err_pulses", err_pulses, exp_err);

        scan_point(12'hFED, 1'b1, 1'b1);
        wait_drain("final");
        check_output("final_err_pulses", err_pulses, exp_err);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
